// File: rtl/vio_route_tagger.sv
// -----------------------------------------------------------------------------
// vio_route_tagger
//
// Per-region ingress stage in front of the vFPGA data switch. Each packet of
// the region's outgoing AXI4-Stream gets a 14-bit route word. That word is
// latched from the config register when the packet's first beat is accepted
// and stays constant until tlast. Packets whose destination port (route[5:3])
// does not exist on the switch (dest >= 2*N_ID) are swallowed whole and
// counted. A 2-entry skid buffer (output register + skid register) keeps
// s_axis_tready registered while sustaining one beat per cycle.
//
// Ports
//   aclk, areset            clock, synchronous active-high reset
//   cfg_route_we/_wdata     route config write
//   cfg_route               currently configured (pending) route
//   s_axis_*                user-logic stream in (valid/ready/data/keep/last/id)
//   m_axis_*                stream out to switch sink, m_axis_route = tdest
//   pkt_cnt / drop_cnt      forwarded / dropped packet counters (wrapping)
// -----------------------------------------------------------------------------
module vio_route_tagger #(
    parameter int          DATA_BITS   = 64,
    parameter int          ID_BITS     = 6,
    parameter int          N_ID        = 3,
    parameter logic [13:0] RESET_ROUTE = 14'h0000
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cfg_route_we,
    input  logic [13:0]            cfg_route_wdata,
    output logic [13:0]            cfg_route,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [ID_BITS-1:0]     s_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [ID_BITS-1:0]     m_axis_tid,
    output logic [13:0]            m_axis_route,
    output logic [31:0]            pkt_cnt,
    output logic [31:0]            drop_cnt
);
    localparam int          KEEP_BITS = DATA_BITS / 8;
    localparam int unsigned N_PORTS   = 2 * N_ID;

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_e;

    state_e                 state_q, state_d;
    logic [13:0]            cfg_route_q, cfg_route_d;
    logic [13:0]            route_q, route_d;
    logic                   s_ready_q, s_ready_d;

    logic                   out_vld_q, out_vld_d;
    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic [KEEP_BITS-1:0]   out_keep_q, out_keep_d;
    logic                   out_last_q, out_last_d;
    logic [ID_BITS-1:0]     out_id_q, out_id_d;
    logic [13:0]            out_route_q, out_route_d;

    logic                   skid_vld_q, skid_vld_d;
    logic [DATA_BITS-1:0]   skid_data_q, skid_data_d;
    logic [KEEP_BITS-1:0]   skid_keep_q, skid_keep_d;
    logic                   skid_last_q, skid_last_d;
    logic [ID_BITS-1:0]     skid_id_q, skid_id_d;
    logic [13:0]            skid_route_q, skid_route_d;

    logic [31:0]            pkt_cnt_q, drop_cnt_q;

    logic                   accept, dest_ok, fwd, discard, out_free;
    logic                   pkt_inc, drop_inc;
    logic [13:0]            beat_route;

    // A first beat (IDLE) takes the config value as it stands this cycle, so a
    // coincident config write only affects the following packet.
    always_comb begin
        accept     = s_axis_tvalid & s_ready_q;
        beat_route = (state_q == ST_IDLE) ? cfg_route_q : route_q;
        dest_ok    = 32'(beat_route[5:3]) < N_PORTS;
        fwd        = accept & (((state_q == ST_IDLE) & dest_ok) | (state_q == ST_PASS));
        discard    = accept & (((state_q == ST_IDLE) & ~dest_ok) | (state_q == ST_DROP));
        pkt_inc    = out_vld_q & m_axis_tready & out_last_q;
        drop_inc   = discard & s_axis_tlast;
    end

    // Packet FSM and config register next state
    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        cfg_route_d = cfg_route_we ? cfg_route_wdata : cfg_route_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    route_d = cfg_route_q;
                    if (!s_axis_tlast) begin
                        state_d = dest_ok ? ST_PASS : ST_DROP;
                    end
                end
            end
            ST_PASS, ST_DROP: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Skid buffer: the output register refills from the skid entry first, so
    // ordering is preserved; a new beat lands in the skid only while the
    // output register is stalled. Ready is computed from the next state so it
    // can be registered without ever overrunning the skid entry.
    always_comb begin
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_id_d     = out_id_q;
        out_route_d  = out_route_q;
        skid_vld_d   = skid_vld_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        skid_id_d    = skid_id_q;
        skid_route_d = skid_route_q;
        out_free     = ~out_vld_q | m_axis_tready;

        if (out_free) begin
            if (skid_vld_q) begin
                out_vld_d   = 1'b1;
                out_data_d  = skid_data_q;
                out_keep_d  = skid_keep_q;
                out_last_d  = skid_last_q;
                out_id_d    = skid_id_q;
                out_route_d = skid_route_q;
                skid_vld_d  = 1'b0;
            end else begin
                out_vld_d = fwd;
                if (fwd) begin
                    out_data_d  = s_axis_tdata;
                    out_keep_d  = s_axis_tkeep;
                    out_last_d  = s_axis_tlast;
                    out_id_d    = s_axis_tid;
                    out_route_d = beat_route;
                end
            end
        end else if (fwd) begin
            skid_vld_d   = 1'b1;
            skid_data_d  = s_axis_tdata;
            skid_keep_d  = s_axis_tkeep;
            skid_last_d  = s_axis_tlast;
            skid_id_d    = s_axis_tid;
            skid_route_d = beat_route;
        end

        s_ready_d = ~skid_vld_d | (state_d == ST_DROP);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            cfg_route_q <= RESET_ROUTE;
            route_q     <= '0;
            s_ready_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            out_route_q <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_route_q <= cfg_route_d;
            route_q     <= route_d;
            s_ready_q   <= s_ready_d;
            out_vld_q   <= out_vld_d;
            skid_vld_q  <= skid_vld_d;
            out_route_q <= out_route_d;
            if (pkt_inc) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (drop_inc) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        out_data_q   <= out_data_d;
        out_keep_q   <= out_keep_d;
        out_last_q   <= out_last_d;
        out_id_q     <= out_id_d;
        skid_data_q  <= skid_data_d;
        skid_keep_q  <= skid_keep_d;
        skid_last_q  <= skid_last_d;
        skid_id_q    <= skid_id_d;
        skid_route_q <= skid_route_d;
    end

    assign cfg_route     = cfg_route_q;
    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tid    = out_id_q;
    assign m_axis_route  = out_route_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_vio_route_tagger.sv
// -----------------------------------------------------------------------------
// tb_vio_route_tagger
//
// Randomized packet stimulus with a packet-level reference model. Expected
// beats are queued at issue time; an independent monitor pops and compares
// whenever the DUT presents a beat that the sink accepts.
// -----------------------------------------------------------------------------
module tb_vio_route_tagger;
    localparam int          DATA_BITS   = 32;
    localparam int          KEEP_BITS   = DATA_BITS / 8;
    localparam int          ID_BITS     = 4;
    localparam int          N_ID        = 3;
    localparam logic [13:0] RESET_ROUTE = 14'h0000;

    logic                 aclk = 1'b0;
    logic                 areset = 1'b1;
    logic                 cfg_route_we = 1'b0;
    logic [13:0]          cfg_route_wdata = '0;
    logic [13:0]          cfg_route;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic [DATA_BITS-1:0] s_axis_tdata = '0;
    logic [KEEP_BITS-1:0] s_axis_tkeep = '0;
    logic                 s_axis_tlast = 1'b0;
    logic [ID_BITS-1:0]   s_axis_tid = '0;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b1;
    logic [DATA_BITS-1:0] m_axis_tdata;
    logic [KEEP_BITS-1:0] m_axis_tkeep;
    logic                 m_axis_tlast;
    logic [ID_BITS-1:0]   m_axis_tid;
    logic [13:0]          m_axis_route;
    logic [31:0]          pkt_cnt;
    logic [31:0]          drop_cnt;

    vio_route_tagger #(
        .DATA_BITS  (DATA_BITS),
        .ID_BITS    (ID_BITS),
        .N_ID       (N_ID),
        .RESET_ROUTE(RESET_ROUTE)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .cfg_route_we   (cfg_route_we),
        .cfg_route_wdata(cfg_route_wdata),
        .cfg_route      (cfg_route),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tid     (s_axis_tid),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tid     (m_axis_tid),
        .m_axis_route   (m_axis_route),
        .pkt_cnt        (pkt_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic [KEEP_BITS-1:0] keep;
        logic                 last;
        logic [ID_BITS-1:0]   id;
        logic [13:0]          route;
        int                   acc_cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [13:0] model_cfg = RESET_ROUTE;
    logic [13:0] pkt_route = '0;
    bit          pkt_ok = 1'b1;
    logic [31:0] exp_pkt = '0;
    logic [31:0] exp_drop = '0;

    // Monitor controls
    bit rnd_ready = 1'b0;
    bit fix_ready = 1'b1;
    bit lat_chk   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic stop_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Monitor: choose the sink ready for the coming edge, then judge the beat
    // that is on the bus for that edge.
    bit                   held = 1'b0;
    logic [DATA_BITS-1:0] h_data;
    logic [KEEP_BITS-1:0] h_keep;
    logic                 h_last;
    logic [ID_BITS-1:0]   h_id;
    logic [13:0]          h_route;

    always @(negedge aclk) begin
        exp_t e;
        m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
        #1;
        if (areset || !m_axis_tvalid) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_data",  m_axis_tdata,  h_data);
                chk("stall_keep",  m_axis_tkeep,  h_keep);
                chk("stall_last",  m_axis_tlast,  h_last);
                chk("stall_id",    m_axis_tid,    h_id);
                chk("stall_route", m_axis_route,  h_route);
            end
            if (sb.size() == 0) begin
                chk("spurious_beat", m_axis_tvalid, 1'b0);
                held = 1'b0;
            end else begin
                if (!held && lat_chk) chk("latency", cyc, sb[0].acc_cyc + 1);
                if (m_axis_tready) begin
                    e = sb.pop_front();
                    chk("beat_data",  m_axis_tdata, e.data);
                    chk("beat_keep",  m_axis_tkeep, e.keep);
                    chk("beat_last",  m_axis_tlast, e.last);
                    chk("beat_id",    m_axis_tid,   e.id);
                    chk("beat_route", m_axis_route, e.route);
                    held = 1'b0;
                end else begin
                    held    = 1'b1;
                    h_data  = m_axis_tdata;
                    h_keep  = m_axis_tkeep;
                    h_last  = m_axis_tlast;
                    h_id    = m_axis_tid;
                    h_route = m_axis_route;
                end
            end
        end
    end

    task automatic send_beat(input logic [DATA_BITS-1:0] d, input logic [KEEP_BITS-1:0] k,
                             input logic [ID_BITS-1:0] id, input bit last, input bit first,
                             input bit do_we, input logic [13:0] we_val, input bit expect_ready);
        int n = 0;
        exp_t e;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tid    = id;
        s_axis_tlast  = last;
        while (!s_axis_tready && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (expect_ready) chk("drop_tready", n, 0);
        if (n >= 300) begin
            chk("tready_timeout", s_axis_tready, 1'b1);
            stop_now();
        end
        if (first) begin
            pkt_route = model_cfg;
            pkt_ok    = int'(pkt_route[5:3]) < 2 * N_ID;
        end
        if (do_we) begin
            cfg_route_we    = 1'b1;
            cfg_route_wdata = we_val;
        end
        if (pkt_ok) begin
            e.data = d; e.keep = k; e.last = last; e.id = id;
            e.route = pkt_route; e.acc_cyc = cyc;
            sb.push_back(e);
        end
        if (last) begin
            if (pkt_ok) exp_pkt = exp_pkt + 32'd1;
            else        exp_drop = exp_drop + 32'd1;
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        cfg_route_we  = 1'b0;
        if (do_we) model_cfg = we_val;
    endtask

    task automatic send_pkt(input int len, input int we_idx, input logic [13:0] we_val,
                            input bit gaps, input bit expect_ready);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge aclk);
            send_beat(DATA_BITS'($urandom), KEEP_BITS'($urandom), ID_BITS'($urandom),
                      i == len - 1, i == 0, i == we_idx, we_val, expect_ready);
        end
    endtask

    task automatic cfg_write(input logic [13:0] v);
        cfg_route_we    = 1'b1;
        cfg_route_wdata = v;
        @(negedge aclk);
        cfg_route_we = 1'b0;
        model_cfg    = v;
        chk("cfg_route", cfg_route, v);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 3000) begin
            chk({tag, "_drain_timeout"}, sb.size(), 0);
            stop_now();
        end
        repeat (3) @(negedge aclk);
        chk({tag, "_pkt_cnt"},  pkt_cnt,  exp_pkt);
        chk({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    endtask

    initial begin
        int fwd_n;
        int iters;
        int len;
        logic [13:0] r;

        // Reset state
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_route",  m_axis_route,  14'h0000);
        chk("rst_cfg",      cfg_route,     RESET_ROUTE);
        chk("rst_pkt_cnt",  pkt_cnt,       32'd0);
        chk("rst_drop_cnt", drop_cnt,      32'd0);
        areset = 1'b0;
        @(negedge aclk);
        chk("tready_after_reset", s_axis_tready, 1'b1);

        // Basic forward with fixed-latency check
        cfg_write(14'h0010);
        fix_ready = 1'b1;
        lat_chk   = 1'b1;
        send_pkt(4, -1, '0, 1'b0, 1'b0);
        drain("basic");

        // Config write mid-packet: in-flight packet keeps its route
        send_pkt(4, 1, 14'h0018, 1'b0, 1'b0);
        send_pkt(4, -1, '0, 1'b0, 1'b0);
        drain("cfg_mid");
        chk("cfg_after_mid", cfg_route, 14'h0018);
        lat_chk = 1'b0;

        // Invalid destination dropped while the sink is stalled
        fix_ready = 1'b0;
        cfg_write(14'h0038);
        send_pkt(3, -1, '0, 1'b0, 1'b1);
        repeat (3) @(negedge aclk);
        chk("drop_no_valid", m_axis_tvalid, 1'b0);
        chk("drop_cnt_after_drop", drop_cnt, exp_drop);
        fix_ready = 1'b1;
        cfg_write(14'h0010);
        send_pkt(2, -1, '0, 1'b0, 1'b0);
        drain("after_drop");

        // Single-beat packets, dropped and forwarded back to back
        cfg_write(14'h0030);
        send_pkt(1, -1, '0, 1'b0, 1'b0);
        cfg_write(14'h0008);
        send_pkt(1, -1, '0, 1'b0, 1'b0);
        send_pkt(1, 0, 14'h0028, 1'b0, 1'b0);
        send_pkt(1, -1, '0, 1'b0, 1'b0);
        drain("single");

        // Randomized traffic with a randomly stalling sink
        rnd_ready = 1'b1;
        fwd_n = 0;
        iters = 0;
        while (fwd_n < 100 && iters < 400) begin
            iters++;
            if ($urandom_range(0, 3) == 0) begin
                r = {8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom)};
                cfg_write(r);
            end
            len = $urandom_range(1, 16);
            r = {8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom)};
            send_pkt(len, ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1,
                     r, 1'b1, 1'b0);
            if (pkt_ok) fwd_n++;
        end
        drain("random");
        rnd_ready = 1'b0;
        fix_ready = 1'b1;

        // Reset during beat 3 of an 8-beat packet
        cfg_write(14'h0010);
        send_beat(32'hA0, 4'hF, 4'h1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        send_beat(32'hA1, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hA2;
        s_axis_tlast  = 1'b0;
        areset        = 1'b1;
        @(negedge aclk);
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        sb.delete();
        model_cfg = RESET_ROUTE;
        exp_pkt   = '0;
        exp_drop  = '0;
        #2;
        chk("midrst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_pkt_cnt",  pkt_cnt,       32'd0);
        chk("midrst_drop_cnt", drop_cnt,      32'd0);
        chk("midrst_cfg",      cfg_route,     RESET_ROUTE);
        @(negedge aclk);
        send_pkt(5, -1, '0, 1'b0, 1'b0);
        drain("post_rst");

        // Packet counter wrap
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        @(negedge aclk);
        release dut.pkt_cnt_q;
        exp_pkt = 32'hFFFF_FFFF;
        @(negedge aclk);
        chk("wrap_preload", pkt_cnt, 32'hFFFF_FFFF);
        send_pkt(2, -1, '0, 1'b0, 1'b0);
        drain("wrap");

        stop_now();
    end

endmodule
